// File: rtl/context_tracker_if.sv
// ============================================================================
// Module      : context_tracker_if
// Description : Fetch/decode/exec/commit handshake bundle for context_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface context_tracker_if #(
    parameter int N_CNTX   = 8,
    parameter int LEN_WORD = 32
);
    logic                init;
    logic                fetch_req;
    logic [LEN_WORD-1:0] fetch_pc;
    logic [N_CNTX-1:0]   fetch_cntx;
    logic                fetch_ack;
    logic                dec_ready;
    logic                dec_pc_known;
    logic                dec_branch;
    logic [LEN_WORD-1:0] dec_next_pc;
    logic [LEN_WORD-1:0] dec_alt_pc;
    logic                ex_jump;
    logic [LEN_WORD-1:0] ex_jump_pc;
    logic                ex_resolve;
    logic [N_CNTX-1:0]   ex_cntx;
    logic                ex_mispredict;
    logic                ret_valid;
    logic [N_CNTX-1:0]   ret_cntx;
    logic                hazard;
    logic [N_CNTX-1:0]   hazard_kill;
    logic [N_CNTX-1:0]   busy;

    // Tracker side
    modport master (
        input  init, fetch_ack, dec_pc_known, dec_branch, dec_next_pc, dec_alt_pc,
               ex_jump, ex_jump_pc, ex_resolve, ex_cntx, ex_mispredict,
               ret_valid, ret_cntx,
        output fetch_req, fetch_pc, fetch_cntx, dec_ready, hazard, hazard_kill, busy
    );

    // Pipeline / environment side
    modport slave (
        output init, fetch_ack, dec_pc_known, dec_branch, dec_next_pc, dec_alt_pc,
               ex_jump, ex_jump_pc, ex_resolve, ex_cntx, ex_mispredict,
               ret_valid, ret_cntx,
        input  fetch_req, fetch_pc, fetch_cntx, dec_ready, hazard, hazard_kill, busy
    );
endinterface

`default_nettype wire

// File: rtl/context_tracker.sv
// ============================================================================
// Module      : context_tracker
// Description : Finite-ring speculative context manager between fetch and exec.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module context_tracker #(
    parameter int                  N_CNTX   = 8,
    parameter int                  LEN_WORD = 32,
    parameter logic [LEN_WORD-1:0] RESET_PC = '0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    context_tracker_if.master   bus
);
    localparam logic [N_CNTX-1:0] C_HOT0 = {{(N_CNTX-1){1'b0}}, 1'b1};

    logic [N_CNTX-1:0]   hot_q, hot_d;
    logic [N_CNTX-1:0]   busy_q, busy_d;
    logic [LEN_WORD-1:0] pc_q, pc_d;
    logic                pending_q, pending_d;
    logic                hazard_q, hazard_d;
    logic [N_CNTX-1:0]   hazard_kill_q, hazard_kill_d;
    logic [N_CNTX-1:0]   kill_q [N_CNTX];
    logic [N_CNTX-1:0]   kill_d [N_CNTX];
    logic [LEN_WORD-1:0] alt_q  [N_CNTX];
    logic [LEN_WORD-1:0] alt_d  [N_CNTX];

    logic [N_CNTX-1:0]   w_next;
    logic [N_CNTX-1:0]   w_kill_h;
    logic [LEN_WORD-1:0] w_alt_h;
    logic                w_resolve;
    logic                w_mispredict;
    logic                w_accept;
    logic                w_retire;

    assign w_next       = {hot_q[N_CNTX-2:0], hot_q[N_CNTX-1]};
    assign w_resolve    = bus.ex_resolve & |(bus.ex_cntx & busy_q);
    assign w_mispredict = w_resolve & bus.ex_mispredict;
    assign w_accept     = bus.fetch_ack & (bus.dec_ready | ~bus.dec_branch)
                          & ~w_mispredict & ~bus.ex_jump;
    // A retire cannot release the hot context nor one that is being squashed
    assign w_retire     = bus.ret_valid & ~|(bus.ret_cntx & hot_q)
                          & ~(w_mispredict & |(bus.ret_cntx & w_kill_h));

    always_comb begin
        w_kill_h = '0;
        w_alt_h  = '0;
        for (int c = 0; c < N_CNTX; c++) begin
            w_kill_h = w_kill_h | (kill_q[c] & {N_CNTX{bus.ex_cntx[c]}});
            w_alt_h  = w_alt_h  | (alt_q[c]  & {LEN_WORD{bus.ex_cntx[c]}});
        end
    end

    always_comb begin
        hot_d         = hot_q;
        busy_d        = busy_q;
        pc_d          = pc_q;
        pending_d     = pending_q;
        hazard_d      = 1'b0;
        hazard_kill_d = '0;
        kill_d        = kill_q;
        alt_d         = alt_q;

        if (w_mispredict) begin
            hazard_d      = 1'b1;
            hazard_kill_d = w_kill_h;
            busy_d        = busy_q & ~w_kill_h;
            hot_d         = bus.ex_cntx;
            pc_d          = w_alt_h;
            pending_d     = 1'b1;
            for (int c = 0; c < N_CNTX; c++) begin
                kill_d[c] = bus.ex_cntx[c] ? '0 : (kill_q[c] & ~w_kill_h);
            end
        end else begin
            if (w_resolve) begin
                for (int c = 0; c < N_CNTX; c++) begin
                    if (bus.ex_cntx[c]) kill_d[c] = '0;
                end
            end
            if (bus.ex_jump) begin
                pc_d      = bus.ex_jump_pc;
                pending_d = 1'b1;
            end else if (w_accept) begin
                pc_d      = bus.dec_pc_known ? bus.dec_next_pc : pc_q;
                pending_d = bus.dec_pc_known;
                if (bus.dec_branch) begin
                    hot_d  = w_next;
                    busy_d = busy_q | w_next;
                    for (int c = 0; c < N_CNTX; c++) begin
                        if (hot_q[c]) alt_d[c] = bus.dec_alt_pc;
                        // The new context dies with the hot one and with every ancestor that would kill it
                        if (hot_q[c] || |(kill_d[c] & hot_q)) kill_d[c] = kill_d[c] | w_next;
                    end
                end
            end
        end

        if (w_retire) begin
            busy_d = busy_d & ~bus.ret_cntx;
            for (int c = 0; c < N_CNTX; c++) begin
                kill_d[c] = kill_d[c] & ~bus.ret_cntx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.init) begin
            hot_q         <= C_HOT0;
            busy_q        <= C_HOT0;
            pc_q          <= RESET_PC;
            pending_q     <= 1'b1;
            hazard_q      <= 1'b0;
            hazard_kill_q <= '0;
            for (int c = 0; c < N_CNTX; c++) begin
                kill_q[c] <= '0;
                alt_q[c]  <= '0;
            end
        end else begin
            hot_q         <= hot_d;
            busy_q        <= busy_d;
            pc_q          <= pc_d;
            pending_q     <= pending_d;
            hazard_q      <= hazard_d;
            hazard_kill_q <= hazard_kill_d;
            kill_q        <= kill_d;
            alt_q         <= alt_d;
        end
    end

    assign bus.fetch_req   = pending_q;
    assign bus.fetch_pc    = pc_q;
    assign bus.fetch_cntx  = hot_q;
    assign bus.dec_ready   = ~|(busy_q & w_next);
    assign bus.hazard      = hazard_q;
    assign bus.hazard_kill = hazard_kill_q;
    assign bus.busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_context_tracker.sv
// ============================================================================
// Module      : tb_context_tracker
// Description : Directed self-checking bench for context_tracker (8- and 4-context rings).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_context_tracker;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    context_tracker_if #(.N_CNTX(8), .LEN_WORD(32)) ifc8 ();
    context_tracker_if #(.N_CNTX(4), .LEN_WORD(32)) ifc4 ();

    context_tracker #(.N_CNTX(8), .LEN_WORD(32), .RESET_PC(32'h0)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (ifc8.master)
    );

    context_tracker #(.N_CNTX(4), .LEN_WORD(32), .RESET_PC(32'h0)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (ifc4.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle8();
        ifc8.init = 0; ifc8.fetch_ack = 0; ifc8.dec_pc_known = 0; ifc8.dec_branch = 0;
        ifc8.dec_next_pc = 0; ifc8.dec_alt_pc = 0; ifc8.ex_jump = 0; ifc8.ex_jump_pc = 0;
        ifc8.ex_resolve = 0; ifc8.ex_cntx = 0; ifc8.ex_mispredict = 0;
        ifc8.ret_valid = 0; ifc8.ret_cntx = 0;
    endtask

    task automatic idle4();
        ifc4.init = 0; ifc4.fetch_ack = 0; ifc4.dec_pc_known = 0; ifc4.dec_branch = 0;
        ifc4.dec_next_pc = 0; ifc4.dec_alt_pc = 0; ifc4.ex_jump = 0; ifc4.ex_jump_pc = 0;
        ifc4.ex_resolve = 0; ifc4.ex_cntx = 0; ifc4.ex_mispredict = 0;
        ifc4.ret_valid = 0; ifc4.ret_cntx = 0;
    endtask

    task automatic ack8(input logic br, input logic known, input logic [31:0] nxt, input logic [31:0] alt);
        ifc8.fetch_ack = 1; ifc8.dec_branch = br; ifc8.dec_pc_known = known;
        ifc8.dec_next_pc = nxt; ifc8.dec_alt_pc = alt;
    endtask

    task automatic ack4(input logic [31:0] nxt, input logic [31:0] alt);
        ifc4.fetch_ack = 1; ifc4.dec_branch = 1; ifc4.dec_pc_known = 1;
        ifc4.dec_next_pc = nxt; ifc4.dec_alt_pc = alt;
    endtask

    task automatic test_reset();
        idle8(); idle4();
        rst = 1;
        step(); step();
        rst = 0;
        step();
        checks++; if (ifc8.fetch_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b exp=1", ifc8.fetch_req); end
        checks++; if (ifc8.fetch_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", ifc8.fetch_pc); end
        checks++; if (ifc8.fetch_cntx !== 8'h01) begin failures++; $display("FAIL reset_cntx got=%h exp=01", ifc8.fetch_cntx); end
        checks++; if (ifc8.busy !== 8'h01) begin failures++; $display("FAIL reset_busy got=%h exp=01", ifc8.busy); end
        checks++; if (ifc8.hazard !== 1'b0 || ifc8.hazard_kill !== 8'h00) begin failures++; $display("FAIL reset_hazard got=%b/%h exp=0/00", ifc8.hazard, ifc8.hazard_kill); end
        checks++; if (ifc4.busy !== 4'h1 || ifc4.fetch_cntx !== 4'h1) begin failures++; $display("FAIL reset4 busy=%h cntx=%h exp=1/1", ifc4.busy, ifc4.fetch_cntx); end
    endtask

    task automatic test_fetch_branch();
        ack8(0, 1, 32'h4, 32'h0);
        step();
        idle8();
        checks++; if (ifc8.fetch_pc !== 32'h4) begin failures++; $display("FAIL ack_pc got=%h exp=4", ifc8.fetch_pc); end
        checks++; if (ifc8.fetch_cntx !== 8'h01 || ifc8.busy !== 8'h01) begin failures++; $display("FAIL ack_noalloc cntx=%h busy=%h exp=01/01", ifc8.fetch_cntx, ifc8.busy); end
        ack8(1, 1, 32'h40, 32'h8);
        #1;
        checks++; if (ifc8.dec_ready !== 1'b1) begin failures++; $display("FAIL br_ready got=%b exp=1", ifc8.dec_ready); end
        step();
        idle8();
        checks++; if (ifc8.fetch_cntx !== 8'h02) begin failures++; $display("FAIL br_cntx got=%h exp=02", ifc8.fetch_cntx); end
        checks++; if (ifc8.fetch_pc !== 32'h40) begin failures++; $display("FAIL br_pc got=%h exp=40", ifc8.fetch_pc); end
        checks++; if (ifc8.busy !== 8'h03) begin failures++; $display("FAIL br_busy got=%h exp=03", ifc8.busy); end
    endtask

    task automatic test_mispredict();
        ack8(1, 1, 32'h80, 32'h44);
        step();
        idle8();
        checks++; if (ifc8.busy !== 8'h07 || ifc8.fetch_cntx !== 8'h04) begin failures++; $display("FAIL nest busy=%h cntx=%h exp=07/04", ifc8.busy, ifc8.fetch_cntx); end
        // mispredict on the oldest context with a colliding ack that must be dropped
        ifc8.ex_resolve = 1; ifc8.ex_mispredict = 1; ifc8.ex_cntx = 8'h01;
        ack8(1, 1, 32'h99, 32'h55);
        step();
        idle8();
        checks++; if (ifc8.hazard !== 1'b1) begin failures++; $display("FAIL mp_hazard got=%b exp=1", ifc8.hazard); end
        checks++; if (ifc8.hazard_kill !== 8'h06) begin failures++; $display("FAIL mp_kill got=%h exp=06", ifc8.hazard_kill); end
        checks++; if (ifc8.fetch_pc !== 32'h8) begin failures++; $display("FAIL mp_pc got=%h exp=8", ifc8.fetch_pc); end
        checks++; if (ifc8.fetch_cntx !== 8'h01 || ifc8.busy !== 8'h01) begin failures++; $display("FAIL mp_state cntx=%h busy=%h exp=01/01", ifc8.fetch_cntx, ifc8.busy); end
        step();
        checks++; if (ifc8.hazard !== 1'b0 || ifc8.hazard_kill !== 8'h00) begin failures++; $display("FAIL mp_pulse got=%b/%h exp=0/00", ifc8.hazard, ifc8.hazard_kill); end
    endtask

    task automatic test_jump();
        ifc8.ex_jump = 1; ifc8.ex_jump_pc = 32'h100;
        ack8(1, 1, 32'h20, 32'h30);
        step();
        idle8();
        checks++; if (ifc8.fetch_pc !== 32'h100) begin failures++; $display("FAIL jump_pc got=%h exp=100", ifc8.fetch_pc); end
        checks++; if (ifc8.busy !== 8'h01 || ifc8.fetch_cntx !== 8'h01) begin failures++; $display("FAIL jump_noalloc busy=%h cntx=%h exp=01/01", ifc8.busy, ifc8.fetch_cntx); end
        ack8(0, 0, 32'h0, 32'h0);
        step();
        idle8();
        checks++; if (ifc8.fetch_req !== 1'b0) begin failures++; $display("FAIL unknown_req got=%b exp=0", ifc8.fetch_req); end
        ifc8.ex_jump = 1; ifc8.ex_jump_pc = 32'h200;
        step();
        idle8();
        checks++; if (ifc8.fetch_req !== 1'b1 || ifc8.fetch_pc !== 32'h200) begin failures++; $display("FAIL jump_resume req=%b pc=%h exp=1/200", ifc8.fetch_req, ifc8.fetch_pc); end
    endtask

    task automatic test_ring_full();
        ack4(32'h10, 32'h11); step();
        ack4(32'h20, 32'h21); step();
        ack4(32'h30, 32'h31); step();
        idle4();
        checks++; if (ifc4.busy !== 4'hF || ifc4.fetch_cntx !== 4'h8) begin failures++; $display("FAIL full busy=%h cntx=%h exp=F/8", ifc4.busy, ifc4.fetch_cntx); end
        ack4(32'h40, 32'h41);
        #1;
        checks++; if (ifc4.dec_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", ifc4.dec_ready); end
        step();
        checks++; if (ifc4.fetch_cntx !== 4'h8 || ifc4.fetch_pc !== 32'h30 || ifc4.busy !== 4'hF) begin failures++; $display("FAIL stall cntx=%h pc=%h busy=%h exp=8/30/F", ifc4.fetch_cntx, ifc4.fetch_pc, ifc4.busy); end
        ifc4.ret_valid = 1; ifc4.ret_cntx = 4'h1;
        step();
        ifc4.ret_valid = 0; ifc4.ret_cntx = 0;
        checks++; if (ifc4.busy !== 4'hE || ifc4.dec_ready !== 1'b1) begin failures++; $display("FAIL retire busy=%h ready=%b exp=E/1", ifc4.busy, ifc4.dec_ready); end
        step();
        idle4();
        checks++; if (ifc4.fetch_cntx !== 4'h1 || ifc4.busy !== 4'hF || ifc4.fetch_pc !== 32'h40) begin failures++; $display("FAIL wrap cntx=%h busy=%h pc=%h exp=1/F/40", ifc4.fetch_cntx, ifc4.busy, ifc4.fetch_pc); end
        ifc4.ret_valid = 1; ifc4.ret_cntx = 4'h1;
        step();
        idle4();
        checks++; if (ifc4.busy !== 4'hF) begin failures++; $display("FAIL ret_hot busy=%h exp=F", ifc4.busy); end
    endtask

    task automatic test_init();
        ack8(1, 1, 32'h300, 32'h304);
        step();
        idle8();
        checks++; if (ifc8.busy !== 8'h03 || ifc8.fetch_cntx !== 8'h02) begin failures++; $display("FAIL pre_init busy=%h cntx=%h exp=03/02", ifc8.busy, ifc8.fetch_cntx); end
        ifc8.init = 1;
        ack8(1, 1, 32'h400, 32'h404);
        ifc8.ex_resolve = 1; ifc8.ex_mispredict = 1; ifc8.ex_cntx = 8'h01;
        step();
        idle8();
        checks++; if (ifc8.hazard !== 1'b0 || ifc8.hazard_kill !== 8'h00) begin failures++; $display("FAIL init_hazard got=%b/%h exp=0/00", ifc8.hazard, ifc8.hazard_kill); end
        checks++; if (ifc8.busy !== 8'h01 || ifc8.fetch_cntx !== 8'h01) begin failures++; $display("FAIL init_state busy=%h cntx=%h exp=01/01", ifc8.busy, ifc8.fetch_cntx); end
        checks++; if (ifc8.fetch_pc !== 32'h0 || ifc8.fetch_req !== 1'b1) begin failures++; $display("FAIL init_pc pc=%h req=%b exp=0/1", ifc8.fetch_pc, ifc8.fetch_req); end
        // cleared masks and alternate PCs show through a squash of the root context
        ifc8.ex_resolve = 1; ifc8.ex_mispredict = 1; ifc8.ex_cntx = 8'h01;
        step();
        idle8();
        checks++; if (ifc8.hazard !== 1'b1 || ifc8.hazard_kill !== 8'h00 || ifc8.fetch_pc !== 32'h0) begin failures++; $display("FAIL init_masks hazard=%b kill=%h pc=%h exp=1/00/0", ifc8.hazard, ifc8.hazard_kill, ifc8.fetch_pc); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1;
        idle8();
        idle4();
        test_reset();
        test_fetch_branch();
        test_mispredict();
        test_jump();
        test_ring_full();
        test_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
